// File: rtl/display_scan_sched.sv
`default_nettype none
// display_scan_sched: digit-scan prescaler, alarm blink and live/diagnostic
// display source arbiter; source switches happen only on frame boundaries.
module display_scan_sched #(
  parameter int PRESC_DIV   = 100000,
  parameter int BLINK_DIV   = 125,
  parameter int DIAG_FRAMES = 500
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [1:0] EstadoSys,
  input  logic       VentSys,
  input  logic       AlarmSys,
  input  logic       BlinkEn,
  input  logic       DiagReq,
  input  logic [1:0] DiagEstado,
  input  logic       DiagVent,
  input  logic       DiagAlarm,
  output logic       ContEnable,
  output logic [1:0] Estado,
  output logic       In0,
  output logic       In1,
  output logic       DiagGnt,
  output logic       DiagDone
);

  localparam int PW = $clog2(PRESC_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int CW = (DIAG_FRAMES > 1) ? $clog2(DIAG_FRAMES) : 1;

  typedef enum logic [1:0] {
    LIVE = 2'd0,
    WAIT = 2'd1,
    SHOW = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] pres;
  logic [1:0]    digit_pos;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph, blink_ph_next;
  logic [CW-1:0] diag_cnt, diag_cnt_next;
  logic          rearm, abort_pend, abort_next, done_next, frame_end;

  assign frame_end = ContEnable && (digit_pos == 2'd3);
  // Blink phase is applied on the boundary edge itself so a frame never mixes phases.
  assign blink_ph_next = (frame_end && (blink_cnt == BW'(BLINK_DIV - 1))) ? ~blink_ph : blink_ph;
  assign DiagGnt = (state == SHOW);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      pres       <= '0;
      ContEnable <= 1'b0;
      digit_pos  <= 2'd0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b1;
    end else begin
      ContEnable <= (pres == PW'(PRESC_DIV - 1));
      pres       <= (pres == PW'(PRESC_DIV - 1)) ? '0 : pres + 1'b1;
      if (ContEnable) digit_pos <= digit_pos + 2'd1;
      if (frame_end) blink_cnt <= (blink_cnt == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt + 1'b1;
      blink_ph <= blink_ph_next;
    end
  end

  always_comb begin
    state_next    = state;
    diag_cnt_next = diag_cnt;
    abort_next    = abort_pend;
    done_next     = 1'b0;
    case (state)
      LIVE: if (DiagReq && rearm) state_next = WAIT;
      WAIT: begin
        if (!DiagReq) begin
          state_next = LIVE;
        end else if (frame_end) begin
          state_next    = SHOW;
          diag_cnt_next = '0;
          abort_next    = 1'b0;
        end
      end
      SHOW: begin
        if (!DiagReq) abort_next = 1'b1;
        if (frame_end) begin
          // Completion takes priority over a request dropped on the same boundary.
          if (diag_cnt == CW'(DIAG_FRAMES - 1)) begin
            state_next    = HOLD;
            done_next     = 1'b1;
            diag_cnt_next = '0;
            abort_next    = 1'b0;
          end else if (abort_pend || !DiagReq) begin
            state_next    = LIVE;
            diag_cnt_next = '0;
            abort_next    = 1'b0;
          end else begin
            diag_cnt_next = diag_cnt + 1'b1;
          end
        end
      end
      HOLD: if (!DiagReq) state_next = LIVE;
      default: state_next = LIVE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= LIVE;
      diag_cnt   <= '0;
      abort_pend <= 1'b0;
      rearm      <= 1'b1;
      DiagDone   <= 1'b0;
      Estado     <= 2'b00;
      In0        <= 1'b0;
      In1        <= 1'b0;
    end else begin
      state      <= state_next;
      diag_cnt   <= diag_cnt_next;
      abort_pend <= abort_next;
      DiagDone   <= done_next;
      if (!DiagReq) rearm <= 1'b1;
      else if (done_next) rearm <= 1'b0;
      if (state_next == SHOW) begin
        Estado <= DiagEstado;
        In0    <= DiagVent;
        In1    <= DiagAlarm;
      end else begin
        Estado <= EstadoSys;
        In0    <= VentSys;
        In1    <= AlarmSys & (blink_ph_next | ~BlinkEn);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/display_scan_sched.md
# display_scan_sched

Scan scheduler and source arbiter for the 4-digit status display. It generates the digit-advance strobe `ContEnable` from a programmable prescaler and tracks the digit currently being driven. It multiplexes two requesters onto the display inputs (`Estado`, `In0`, `In1`): the live alarm-system status, and a diagnostic requester that borrows the display for a fixed number of full frames through a req/gnt/done handshake. Source switches occur only at frame boundaries, so a frame never shows mixed content. It also blinks the live alarm digit.

## Interface
- `PRESC_DIV`, default 100000: `CLK` cycles between `ContEnable` pulses. Must be ≥2.
- `BLINK_DIV`, default 125: frames per blink half-period.
- `DIAG_FRAMES`, default 500: frames granted to the diagnostic requester per grant. Must be ≥1.
- `CLK`  in  1  system clock; everything is clocked on the rising edge.
- `Reset`  in  1  synchronous, active-high.
- `EstadoSys`  in  2  live system state.
- `VentSys`  in  1  live fan output.
- `AlarmSys`  in  1  live alarm output.
- `BlinkEn`  in  1  when 1, the live alarm digit blinks.
- `DiagReq`  in  1  diagnostic request (level).
- `DiagEstado`  in  2  diagnostic state value.
- `DiagVent`  in  1  diagnostic fan value.
- `DiagAlarm`  in  1  diagnostic alarm value.
- `ContEnable`  out  1  single-cycle digit-advance strobe to the display.
- `Estado`  out  2  state value to the display.
- `In0`  out  1  fan value to the display.
- `In1`  out  1  alarm value to the display.
- `DiagGnt`  out  1  display owned by the diagnostic requester.
- `DiagDone`  out  1  single-cycle pulse: the granted frames are complete.

## Operation
- **Prescaler**
  - Counter `Pres` runs 0..PRESC_DIV-1 and wraps.
  - `ContEnable` is registered: it is high for exactly one cycle, on the edge after `Pres` = PRESC_DIV-1.
  - Pulse period is exactly PRESC_DIV cycles.
- **Digit position**
  - 2-bit `DigitPos` increments on every `ContEnable` and wraps 3→0.
  - It mirrors the display's digit counter; both are reset by the same `Reset`.
- **Frame boundary (FB)**: `ContEnable` is high while `DigitPos` = 3.
- **Blink**
  - Frame counter 0..BLINK_DIV-1 counts FBs.
  - `BlinkPh` toggles when the counter wraps.
- **Live source**: `In1` = `AlarmSys` & (`BlinkPh` | ~`BlinkEn`). `In0` = `VentSys`. `Estado` = `EstadoSys`.
- **Diagnostic source**: values pass through unmodified, with no blink.
- **FSM states**: LIVE, WAIT, SHOW, HOLD.
  - LIVE → WAIT when `DiagReq` = 1 and the re-arm flag is set.
  - WAIT → SHOW at the next FB if `DiagReq` is still 1. WAIT → LIVE immediately if `DiagReq` drops.
  - SHOW: `DiagGnt` = 1 and `DiagCnt` counts FBs.
    - At the FB where `DiagCnt` = DIAG_FRAMES-1: go to HOLD, pulse `DiagDone`, and clear the re-arm flag.
    - If `DiagReq` drops while in SHOW: abort at the next FB to LIVE, with no `DiagDone`.
  - HOLD: the live source drives the display. Go to LIVE once `DiagReq` = 0.
  - The re-arm flag is set whenever `DiagReq` = 0. A held request therefore never re-grants without a low cycle.
- **Source switching**: the output source changes only on an FB edge, the same edge on which `DigitPos` returns to 0. The new source is valid for the whole of digit 0 onward.
- **Reset values**:
  - Outputs: `ContEnable`=0, `Estado`=2'b00, `In0`=0, `In1`=0, `DiagGnt`=0, `DiagDone`=0.
  - Internal state: `Pres`=0, `DigitPos`=0, `BlinkPh`=1, blink counter 0, `DiagCnt`=0, FSM=LIVE, re-arm=1.
- **Reset mid-grant**: immediate return to LIVE. No `DiagDone` is issued.
- **Simultaneous events**:
  - `DiagReq` rising on an FB cycle while in LIVE: go to WAIT. The grant waits for the *next* FB.
  - `DiagReq` falling on the FB that completes SHOW: completion wins, `DiagDone` pulses, and the FSM goes to HOLD, which then exits to LIVE.

## Timing
- After `Reset` deasserts, the first `ContEnable` is high after the PRESC_DIV-th rising edge.
- Data outputs are registered, with 1-cycle latency from the selected inputs when no source switch is involved.
- `DiagGnt` rises and falls on FB edges only.
- `DiagDone` is coincident with `DiagGnt` falling.
- Worst-case grant latency is 4·PRESC_DIV + 1 cycles after `DiagReq` rises.
- Grant duration is exactly 4·PRESC_DIV·DIAG_FRAMES cycles.

## Test plan
All scenarios use PRESC_DIV=4, BLINK_DIV=2, DIAG_FRAMES=2.

1. Reset for 3 cycles, then release → `ContEnable` pulses every 4 cycles. `DigitPos` runs 0,1,2,3,0. All outputs are 0 during reset.
2. `EstadoSys`=2'b10, `VentSys`=1, `AlarmSys`=1, `BlinkEn`=1 → `Estado`=2'b10, `In0`=1. `In1` alternates 1/0 every 2 frames (32 cycles). With `BlinkEn`=0, `In1` stays 1.
3. `DiagReq` rises mid-frame with `DiagEstado`=2'b01 → `DiagGnt` rises at the next FB, and `Estado`=2'b01 for exactly 32 cycles. `DiagDone` pulses once, then live values return.
4. `DiagReq` held high after `DiagDone` → no second grant. Drop `DiagReq` for 1 cycle and raise it again → granted at the following FB.
5. `DiagReq` dropped in SHOW after 1 frame → live source returns at the next FB. `DiagDone` is never asserted.
6. `Reset` asserted during SHOW → `DiagGnt`=0 and outputs are 0 on the next edge. After release, the FSM is in LIVE and `Pres` restarts from 0.
